// File: rtl/dec_seq_ctrl.sv
// Sequencer for the matrix/band thermometer decoder. It buffers samples in a small FIFO,
// runs the enable/warm-up sequence, and drives clamped codes with a 2-bit offset.
module dec_seq_ctrl #(
  parameter int         FIFO_DEPTH = 4,
  parameter int         WARM_W     = 8,
  parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
  input  logic              dec_clk,
  input  logic              dec_rst,
  input  logic              csr_en,
  input  logic [WARM_W-1:0] csr_warmup,
  input  logic [1:0]        csr_os_mode,
  input  logic [1:0]        csr_os_fixed,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_mtrx,
  input  logic [7:0]        in_band,
  output logic [7:0]        s_mtrx,
  output logic [7:0]        s_band,
  output logic [1:0]        os_bin,
  output logic              dec_en,
  output logic              underflow,
  output logic              busy
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, WARMUP, RUN} st_e;
  typedef struct packed {
    logic [7:0] mtrx;
    logic [7:0] band;
  } smp_t;

  st_e             state, state_nxt;
  smp_t            mem [FIFO_DEPTH];
  smp_t            head;
  logic [AW:0]     wptr, rptr;
  logic [WARM_W-1:0] cnt;
  logic [7:0]      lfsr, lfsr_nxt, lim, mtrx_cl;
  logic [1:0]      os_nxt;
  logic            empty, full, push, pop, flush;

  // Extra pointer bit separates full from empty when the index bits match.
  assign empty    = (wptr == rptr);
  assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign in_ready = csr_en && (state != IDLE) && !full;
  assign push     = in_valid && in_ready;
  assign pop      = csr_en && (state == RUN) && !empty;
  assign flush    = !csr_en || (state == IDLE);
  assign head     = mem[rptr[AW-1:0]];
  assign dec_en   = (state != IDLE);
  assign busy     = (state != IDLE);

  assign lfsr_nxt = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

  always_comb begin
    os_nxt = csr_os_fixed;
    case (csr_os_mode)
      2'd1:    os_nxt = os_bin + 2'd1;
      2'd2:    os_nxt = lfsr_nxt[1:0];
      default: os_nxt = csr_os_fixed;
    endcase
  end

  // Clamp so the decoder's s_mtrx + os_bin sum never wraps past 255.
  assign lim     = 8'hFF - {6'd0, os_nxt};
  assign mtrx_cl = (head.mtrx > lim) ? lim : head.mtrx;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (csr_en) state_nxt = WARMUP;
      WARMUP:  if (cnt >= csr_warmup) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
    if (!csr_en) state_nxt = IDLE;
  end

  always_ff @(posedge dec_clk) begin
    if (dec_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge dec_clk) begin
    if (push) mem[wptr[AW-1:0]] <= '{mtrx: in_mtrx, band: in_band};
  end

  always_ff @(posedge dec_clk) begin
    if (dec_rst || flush) begin
      wptr   <= '0;
      rptr   <= '0;
      cnt    <= '0;
      lfsr   <= LFSR_SEED;
      s_mtrx <= '0;
      s_band <= '0;
      os_bin <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (state == WARMUP) cnt <= cnt + 1'b1;
      if (pop) begin
        s_mtrx <= mtrx_cl;
        s_band <= head.band;
        os_bin <= os_nxt;
        if (csr_os_mode == 2'd2) lfsr <= lfsr_nxt;
      end
    end
  end

  // Sticky across IDLE; only a fresh enable (or reset) clears it.
  always_ff @(posedge dec_clk) begin
    if (dec_rst)                                underflow <= 1'b0;
    else if (state == IDLE && csr_en)           underflow <= 1'b0;
    else if (state == RUN && csr_en && empty)   underflow <= 1'b1;
  end

endmodule

// File: tb/tb_dec_seq_ctrl.sv
// Directed bench for dec_seq_ctrl: enable sequence, streaming, offset modes,
// backpressure, underflow and mid-stream disable.
module tb_dec_seq_ctrl;
  logic       dec_clk = 1'b0;
  logic       dec_rst = 1'b1;
  logic       csr_en = 1'b0;
  logic [7:0] csr_warmup = 8'd0;
  logic [1:0] csr_os_mode = 2'd0;
  logic [1:0] csr_os_fixed = 2'd0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_mtrx = 8'd0;
  logic [7:0] in_band = 8'd0;
  logic [7:0] s_mtrx, s_band;
  logic [1:0] os_bin;
  logic       dec_en, underflow, busy;

  int n_cmp = 0;
  int n_err = 0;

  dec_seq_ctrl #(.FIFO_DEPTH(4), .WARM_W(8), .LFSR_SEED(8'hA5)) dut (
    .dec_clk(dec_clk), .dec_rst(dec_rst), .csr_en(csr_en), .csr_warmup(csr_warmup),
    .csr_os_mode(csr_os_mode), .csr_os_fixed(csr_os_fixed), .in_valid(in_valid),
    .in_ready(in_ready), .in_mtrx(in_mtrx), .in_band(in_band), .s_mtrx(s_mtrx),
    .s_band(s_band), .os_bin(os_bin), .dec_en(dec_en), .underflow(underflow), .busy(busy)
  );

  always #5 dec_clk = ~dec_clk;

  task automatic restart(input logic [7:0] wu, input logic [1:0] mode, input logic [1:0] fx);
    @(negedge dec_clk);
    dec_rst = 1'b1; csr_en = 1'b0; in_valid = 1'b0;
    csr_warmup = wu; csr_os_mode = mode; csr_os_fixed = fx;
    @(negedge dec_clk);
    @(negedge dec_clk);
    dec_rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge dec_clk);
    dec_rst = 1'b1; csr_en = 1'b1; in_valid = 1'b1; in_mtrx = 8'h5A; in_band = 8'hC3;
    @(negedge dec_clk);
    @(negedge dec_clk);
    #1;
    n_cmp++; if ({in_ready, dec_en, busy, underflow} !== 4'b0000) begin
      n_err++; $display("FAIL reset_ctrl got %b want 0000", {in_ready, dec_en, busy, underflow}); end
    n_cmp++; if ({s_mtrx, s_band, os_bin} !== 18'd0) begin
      n_err++; $display("FAIL reset_data got %h/%h/%0d want 0", s_mtrx, s_band, os_bin); end
    in_valid = 1'b0; csr_en = 1'b0;
  endtask

  task automatic test_enable();
    restart(8'd3, 2'd0, 2'd0);
    for (int c = 0; c <= 6; c++) begin
      @(negedge dec_clk);
      csr_en = 1'b1;
      #1;
      if (c == 0) begin
        n_cmp++; if ({dec_en, busy, in_ready} !== 3'b000) begin
          n_err++; $display("FAIL en_idle c=%0d got %b want 000", c, {dec_en, busy, in_ready}); end
      end
      if (c >= 1 && c <= 4) begin
        n_cmp++; if ({dec_en, busy} !== 2'b11 || {s_mtrx, s_band, os_bin} !== 18'd0) begin
          n_err++; $display("FAIL en_warm c=%0d got en=%b busy=%b m=%h want 1 1 0", c, dec_en, busy, s_mtrx); end
      end
      if (c == 5) begin
        n_cmp++; if (underflow !== 1'b0) begin
          n_err++; $display("FAIL en_run_early got underflow=%b want 0", underflow); end
      end
      if (c == 6) begin
        n_cmp++; if (underflow !== 1'b1) begin
          n_err++; $display("FAIL en_run_entry got underflow=%b want 1", underflow); end
      end
    end
  endtask

  task automatic test_stream_fixed();
    logic [7:0] vm [3] = '{8'h10, 8'h20, 8'hFF};
    logic [7:0] vb [3] = '{8'h12, 8'h34, 8'h56};
    logic [7:0] em [3] = '{8'h10, 8'h20, 8'hFD};
    restart(8'd0, 2'd0, 2'd2);
    for (int c = 0; c <= 7; c++) begin
      @(negedge dec_clk);
      csr_en = 1'b1;
      in_valid = (c >= 2 && c <= 4);
      if (c >= 2 && c <= 4) begin in_mtrx = vm[c-2]; in_band = vb[c-2]; end
      #1;
      if (c >= 2 && c <= 4) begin
        n_cmp++; if (in_ready !== 1'b1) begin
          n_err++; $display("FAIL fix_ready c=%0d got %b want 1", c, in_ready); end
      end
      if (c == 3) begin
        n_cmp++; if (s_mtrx !== 8'h00) begin
          n_err++; $display("FAIL fix_latency got %h want 00", s_mtrx); end
      end
      if (c >= 4 && c <= 6) begin
        n_cmp++; if (s_mtrx !== em[c-4] || s_band !== vb[c-4] || os_bin !== 2'd2) begin
          n_err++; $display("FAIL fix_out c=%0d got %h/%h/%0d want %h/%h/2", c, s_mtrx, s_band, os_bin, em[c-4], vb[c-4]); end
      end
      if (c == 7) begin
        n_cmp++; if (s_mtrx !== 8'hFD) begin
          n_err++; $display("FAIL fix_hold got %h want FD", s_mtrx); end
      end
    end
  endtask

  task automatic test_rotate();
    logic [1:0] eo [6] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
    restart(8'd0, 2'd1, 2'd3);
    for (int c = 0; c <= 9; c++) begin
      @(negedge dec_clk);
      csr_en = 1'b1;
      in_valid = (c >= 2 && c <= 7);
      in_mtrx = 8'h80; in_band = 8'h0F;
      #1;
      if (c >= 4) begin
        n_cmp++; if (os_bin !== eo[c-4] || s_mtrx !== 8'h80) begin
          n_err++; $display("FAIL rot c=%0d got os=%0d m=%h want os=%0d m=80", c, os_bin, s_mtrx, eo[c-4]); end
      end
    end
  endtask

  task automatic test_lfsr();
    logic [1:0] eo [4] = '{2'd2, 2'd1, 2'd2, 2'd0};
    logic [7:0] em [4] = '{8'hFD, 8'hFE, 8'hFD, 8'hFF};
    restart(8'd0, 2'd2, 2'd0);
    for (int c = 0; c <= 7; c++) begin
      @(negedge dec_clk);
      csr_en = 1'b1;
      in_valid = (c >= 2 && c <= 5);
      in_mtrx = 8'hFF; in_band = 8'hAA;
      #1;
      if (c >= 4) begin
        n_cmp++; if (os_bin !== eo[c-4] || s_mtrx !== em[c-4]) begin
          n_err++; $display("FAIL lfsr c=%0d got os=%0d m=%h want os=%0d m=%h", c, os_bin, s_mtrx, eo[c-4], em[c-4]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    restart(8'd10, 2'd0, 2'd0);
    for (int c = 0; c <= 20; c++) begin
      @(negedge dec_clk);
      csr_en = 1'b1;
      in_valid = (c >= 1 && c <= 5) || (c == 18);
      if (c >= 1 && c <= 5) in_mtrx = 8'hA0 + 8'(c - 1);
      if (c == 18) in_mtrx = 8'h55;
      in_band = 8'h01;
      #1;
      if (c >= 1 && c <= 5) begin
        n_cmp++; if (in_ready !== (c <= 4)) begin
          n_err++; $display("FAIL bp_fill c=%0d got in_ready=%b want %b", c, in_ready, (c <= 4)); end
      end
      if (c == 12 || c == 13) begin
        n_cmp++; if (in_ready !== (c == 13)) begin
          n_err++; $display("FAIL bp_run_ready c=%0d got %b want %b", c, in_ready, (c == 13)); end
      end
      if (c >= 13 && c <= 16) begin
        n_cmp++; if (s_mtrx !== 8'hA0 + 8'(c - 13)) begin
          n_err++; $display("FAIL bp_order c=%0d got %h want %h", c, s_mtrx, 8'hA0 + 8'(c - 13)); end
      end
      if (c == 16) begin
        n_cmp++; if (underflow !== 1'b0) begin
          n_err++; $display("FAIL uf_early got %b want 0", underflow); end
      end
      if (c == 17 || c == 19) begin
        n_cmp++; if (s_mtrx !== 8'hA3 || underflow !== 1'b1) begin
          n_err++; $display("FAIL uf_hold c=%0d got m=%h uf=%b want A3 1", c, s_mtrx, underflow); end
      end
      if (c == 20) begin
        n_cmp++; if (s_mtrx !== 8'h55 || underflow !== 1'b1) begin
          n_err++; $display("FAIL uf_sticky got m=%h uf=%b want 55 1", s_mtrx, underflow); end
      end
    end
  endtask

  task automatic test_disable();
    restart(8'd4, 2'd2, 2'd0);
    for (int c = 0; c <= 11; c++) begin
      @(negedge dec_clk);
      csr_en = (c != 7);
      if (c == 8) csr_warmup = 8'd0;
      in_valid = (c >= 1 && c <= 4) || (c == 7) || (c == 9);
      in_mtrx = (c == 7) ? 8'h99 : (c == 9) ? 8'h66 : 8'h11 * 8'(c);
      in_band = (c == 9) ? 8'h77 : 8'h00;
      #1;
      if (c == 7) begin
        n_cmp++; if (s_mtrx !== 8'h11 || os_bin !== 2'd2 || in_ready !== 1'b0) begin
          n_err++; $display("FAIL dis_pre got m=%h os=%0d rdy=%b want 11 2 0", s_mtrx, os_bin, in_ready); end
      end
      if (c == 8) begin
        n_cmp++; if ({dec_en, busy, in_ready} !== 3'b000 || {s_mtrx, s_band, os_bin} !== 18'd0) begin
          n_err++; $display("FAIL dis_idle got en=%b busy=%b rdy=%b m=%h os=%0d want 0", dec_en, busy, in_ready, s_mtrx, os_bin); end
      end
      if (c == 9) begin
        n_cmp++; if (in_ready !== 1'b1 || dec_en !== 1'b1) begin
          n_err++; $display("FAIL dis_rewarm got rdy=%b en=%b want 1 1", in_ready, dec_en); end
      end
      if (c == 11) begin
        n_cmp++; if (s_mtrx !== 8'h66 || s_band !== 8'h77 || os_bin !== 2'd2) begin
          n_err++; $display("FAIL dis_first got %h/%h/%0d want 66/77/2", s_mtrx, s_band, os_bin); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_enable();
    test_reset();
    test_stream_fixed();
    test_rotate();
    test_lfsr();
    test_back_to_back();
    test_disable();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
